// File: rtl/addsub_checker_8bit.sv
// Response checker for an 8-bit adder/subtractor: recomputes each vector's
// sum/difference and carry, compares against the unit, and keeps pass/fail statistics.
module addsub_checker_8bit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  input  logic             done,
  input  logic             clr,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] exp_s,
  output logic             exp_cout,
  output logic             status_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] cap_a, cap_b, cap_s;
  logic             cap_sel, cap_cout, cap_valid;
  logic [CNT_W-1:0] cap_idx, vec_idx;

  logic             handshake;
  logic             do_clear;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   exp_sum;
  logic             match;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    handshake  = 1'b0;
    do_clear   = 1'b0;
    case (state)
      RUN: begin
        handshake = in_valid & in_ready;
        if (done) next_state = DRAIN;
      end
      DRAIN:   next_state = REPORT;
      REPORT: begin
        if (clr) begin
          do_clear   = 1'b1;
          next_state = RUN;
        end
      end
      default: next_state = RUN;
    endcase
  end

  // Subtraction as a + ~b + 1 so the carry out means "no borrow" (a >= b).
  always_comb begin
    b_op    = cap_sel ? ~cap_b : cap_b;
    exp_sum = {1'b0, cap_a} + {1'b0, b_op} + (WIDTH+1)'(cap_sel);
    match   = (exp_sum[WIDTH-1:0] == cap_s) && (exp_sum[WIDTH] == cap_cout);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready       <= 1'b0;
      status_valid   <= 1'b0;
      cap_valid      <= 1'b0;
      cap_a          <= '0;
      cap_b          <= '0;
      cap_s          <= '0;
      cap_sel        <= 1'b0;
      cap_cout       <= 1'b0;
      cap_idx        <= '0;
      vec_idx        <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      err            <= 1'b0;
      first_fail_idx <= '0;
      exp_s          <= '0;
      exp_cout       <= 1'b0;
    end else begin
      in_ready     <= (next_state == RUN);
      status_valid <= (state == REPORT) && (next_state == REPORT);
      cap_valid    <= handshake;

      if (handshake) begin
        cap_a    <= a;
        cap_b    <= b;
        cap_s    <= s;
        cap_sel  <= sel;
        cap_cout <= cout;
        cap_idx  <= vec_idx;
        if (vec_idx != CNT_MAX) vec_idx <= vec_idx + CNT_W'(1);
      end

      // Compare the vector captured on the previous edge.
      if (cap_valid) begin
        exp_s    <= exp_sum[WIDTH-1:0];
        exp_cout <= exp_sum[WIDTH];
        if (match) begin
          if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
          if (!err) first_fail_idx <= cap_idx;
          err <= 1'b1;
        end
      end

      if (do_clear) begin
        pass_cnt       <= '0;
        fail_cnt       <= '0;
        err            <= 1'b0;
        first_fail_idx <= '0;
        vec_idx        <= '0;
      end
    end
  end

endmodule

// File: doc/addsub_checker_8bit.md
# addsub_checker_8bit

Sequential response checker for the 8-bit adder/subtractor: it sits on the result side of the adder/subtractor test interface and consumes one operand/result vector per handshake. For each vector it computes the expected sum or difference and carry, compares them with the unit's outputs, and keeps pass/fail statistics. On an end-of-test request it drains and presents a held summary until cleared or reset.

## Interface
- WIDTH, 8, operand/result width.
- CNT_W, 8, width of pass/fail/index counters.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  vector present on a/b/sel/s/cout.
- in_ready  output  1  checker can accept a vector this cycle.
- a  input  WIDTH  operand A as applied to the adder/subtractor.
- b  input  WIDTH  operand B.
- sel  input  1  0 = add, 1 = subtract.
- s  input  WIDTH  result S produced by the unit under check.
- cout  input  1  carry out produced by the unit.
- done  input  1  end-of-test request (single-cycle pulse).
- clr  input  1  leave report, zero statistics (honoured only in REPORT).
- pass_cnt  output  CNT_W  vectors matched.
- fail_cnt  output  CNT_W  vectors mismatched.
- err  output  1  sticky: at least one mismatch since reset/clr.
- first_fail_idx  output  CNT_W  index (0-based) of first mismatching vector; meaningful only when err=1.
- exp_s  output  WIDTH  expected S of most recently checked vector.
- exp_cout  output  1  expected carry of most recently checked vector.
- status_valid  output  1  summary stable and final.

## Operation
- Expected values, computed on the captured vector:
  - sel=0: {exp_cout, exp_s} = a + b, a WIDTH+1-bit sum.
  - sel=1: exp_s = (a + ~b + 1) mod 2^WIDTH; exp_cout = carry out of that sum, i.e. 1 iff a >= b unsigned. 0x00 - 0x00 gives exp_cout=1.
- A vector matches iff s == exp_s and cout == exp_cout. Both must agree.
- The capture register holds a, b, sel, s, cout and a capture-valid bit. vec_idx counts accepted vectors.
- On the compare edge:
  - Match: pass_cnt increments.
  - Mismatch: fail_cnt increments and err sets. On the first mismatch only, first_fail_idx takes vec_idx of that vector.
- pass_cnt, fail_cnt and vec_idx saturate at 2^CNT_W-1; they never wrap.
- FSM states RUN, DRAIN, REPORT:
  - RUN: in_ready=1, status_valid=0. Handshake = in_valid & in_ready. On done, go to DRAIN. A vector and done in the same cycle: the vector is accepted and counted.
  - DRAIN: in_ready=0 for one cycle while the last capture is compared, then go to REPORT.
  - REPORT: in_ready=0, status_valid=1, all outputs held. done is ignored. clr zeroes the counters, err, first_fail_idx and vec_idx, then returns to RUN.
- clr outside REPORT is ignored. in_valid with in_ready=0 is not consumed; the source must hold the vector.
- Reset values: in_ready=0 during the reset cycle and 1 from the first cycle after reset. pass_cnt=0, fail_cnt=0, err=0, first_fail_idx=0, exp_s=0, exp_cout=0, status_valid=0, FSM=RUN, capture-valid=0.

## Timing
- Vector accepted at edge k; compare and counter update at edge k+1. Throughput is one vector per cycle in RUN.
- exp_s and exp_cout update at edge k+1, together with the counters.
- done sampled at edge d: DRAIN during cycle d..d+1; status_valid=1 after edge d+2 and held while in REPORT.
- Reset mid-operation: rst has priority over every input, including a handshake or done in the same cycle. An in-flight capture is discarded and not counted.
- clr sampled at edge c in REPORT: status_valid=0 and counters=0 visible after edge c; a new vector can be accepted at edge c+1.

## Test plan
- Add: a=0x14, b=0xD4, sel=0, s=0xE8, cout=0, then a=0x4C, b=0xD5, sel=0, s=0x21, cout=1 -> pass_cnt=2, fail_cnt=0, err=0, exp_s=0x21, exp_cout=1.
- Subtract: a=0xF4, b=0xD6, sel=1, s=0x1E, cout=1, then a=0x2B, b=0x34, sel=1, s=0xF7, cout=0 -> both pass; exp_cout=0 on the second vector.
- Injected faults:
  - Vector 0 (a=0x15, b=0x50, sel=0, s=0x65, cout=0) -> passes.
  - Vector 1: a=0x34, b=0x14, sel=1, s=0x20 (correct), cout=0 (wrong) -> fail_cnt=1, err=1, first_fail_idx=1.
  - Vector 2: s wrong -> fail_cnt=2, first_fail_idx stays 1.
- done asserted with a final valid vector in the same cycle -> vector counted; status_valid=1 two edges later; in_ready=0 while status_valid=1; later in_valid pulses change nothing; clr -> all zero, in_ready=1.
- Saturation: 260 passing vectors with CNT_W=8 -> pass_cnt=255, no wrap.
- rst asserted the cycle after a failing vector is accepted -> fail_cnt=0, err=0, status_valid=0, in_ready=0 during the reset cycle, then 1.
